// File: rtl/program_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: widths, defaults,
// FSM state encoding and the write-address helper.
package program_loader_pkg;

    localparam int HALF_WORD = 16;
    localparam int WORD      = 16;
    localparam int LENGTH_W  = 16;

    localparam int unsigned    DEF_MAX_HALF_WORDS = 1024;
    localparam logic [WORD-1:0] DEF_START_ADDR    = 16'h0000;
    localparam logic [WORD-1:0] DEF_ADDR_STEP     = 16'h0002;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RECV_LO = 3'd1,
        RECV_HI = 3'd2,
        WRITE   = 3'd3,
        RUN     = 3'd4
    } loader_state_t;

    // Address of the n-th halfword; wraps modulo 2^WORD by construction.
    function automatic logic [WORD-1:0] halfword_addr(
        input logic [LENGTH_W-1:0] count,
        input logic [WORD-1:0]     start,
        input logic [WORD-1:0]     step
    );
        logic [WORD-1:0] offset;
        offset = WORD'(count) * step;
        return start + offset;
    endfunction

endpackage

// File: rtl/program_loader.sv
// Boot-time loader: packs a little-endian byte stream into halfwords, writes
// them to CPU program memory and holds the CPU in reset until the load ends.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned     MAX_HALF_WORDS = DEF_MAX_HALF_WORDS,
    parameter logic [WORD-1:0] START_ADDR     = DEF_START_ADDR,
    parameter logic [WORD-1:0] ADDR_STEP      = DEF_ADDR_STEP
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic [LENGTH_W-1:0]  length_i,
    input  logic                 byte_valid_i,
    input  logic [7:0]           byte_data_i,
    output logic                 byte_ready_o,
    output logic                 program_mem_write_en_o,
    output logic [HALF_WORD-1:0] instruction_o,
    output logic [WORD-1:0]      instruction_addr_o,
    output logic                 cpu_reset_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o
);

    localparam logic [LENGTH_W-1:0] MAX_LEN = LENGTH_W'(MAX_HALF_WORDS);

    loader_state_t        state_r;
    loader_state_t        next_state_s;
    logic [LENGTH_W-1:0]  count_r;
    logic [LENGTH_W-1:0]  next_count_s;
    logic [LENGTH_W-1:0]  length_r;
    logic [LENGTH_W-1:0]  next_length_s;
    logic [7:0]           lo_byte_r;
    logic [7:0]           next_lo_byte_s;
    logic [HALF_WORD-1:0] next_instr_s;
    logic [WORD-1:0]      next_addr_s;
    logic                 next_error_s;
    logic                 byte_take_s;
    logic [LENGTH_W-1:0]  count_inc_s;

    // Next-state, datapath and status decisions for the loader FSM.
    always_comb begin
        next_state_s   = state_r;
        next_count_s   = count_r;
        next_length_s  = length_r;
        next_lo_byte_s = lo_byte_r;
        next_instr_s   = instruction_o;
        next_addr_s    = instruction_addr_o;
        next_error_s   = error_o;
        byte_take_s    = byte_valid_i && byte_ready_o;
        count_inc_s    = count_r + 16'd1;
        case (state_r)
            IDLE, RUN: begin
                if (start_i) begin
                    if (length_i > MAX_LEN) begin
                        next_error_s = 1'b1;
                    end else begin
                        next_error_s  = 1'b0;
                        next_count_s  = 16'd0;
                        next_length_s = length_i;
                        next_state_s  = (length_i == 16'd0) ? RUN : RECV_LO;
                    end
                end else begin
                    next_state_s = state_r;
                end
            end
            RECV_LO: begin
                if (byte_take_s) begin
                    next_lo_byte_s = byte_data_i;
                    next_state_s   = RECV_HI;
                end else begin
                    next_state_s = RECV_LO;
                end
            end
            RECV_HI: begin
                // The instruction register only changes on entry to WRITE.
                if (byte_take_s) begin
                    next_instr_s = {byte_data_i, lo_byte_r};
                    next_addr_s  = halfword_addr(count_r, START_ADDR, ADDR_STEP);
                    next_state_s = WRITE;
                end else begin
                    next_state_s = RECV_HI;
                end
            end
            WRITE: begin
                next_count_s = count_inc_s;
                if (count_inc_s == length_r) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = RECV_LO;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs decoded from the upcoming state.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r                <= IDLE;
            count_r                <= 16'd0;
            length_r               <= 16'd0;
            lo_byte_r              <= 8'd0;
            instruction_o          <= 16'd0;
            instruction_addr_o     <= START_ADDR;
            error_o                <= 1'b0;
            byte_ready_o           <= 1'b0;
            program_mem_write_en_o <= 1'b0;
            busy_o                 <= 1'b0;
            cpu_reset_o            <= 1'b1;
            done_o                 <= 1'b0;
        end else begin
            state_r                <= next_state_s;
            count_r                <= next_count_s;
            length_r               <= next_length_s;
            lo_byte_r              <= next_lo_byte_s;
            instruction_o          <= next_instr_s;
            instruction_addr_o     <= next_addr_s;
            error_o                <= next_error_s;
            byte_ready_o           <= (next_state_s == RECV_LO) || (next_state_s == RECV_HI);
            program_mem_write_en_o <= (next_state_s == WRITE);
            busy_o                 <= (next_state_s == RECV_LO) || (next_state_s == RECV_HI) ||
                                      (next_state_s == WRITE);
            cpu_reset_o            <= (next_state_s != RUN);
            done_o                 <= (next_state_s == RUN);
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader.
module tb_program_loader;
    import program_loader_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [15:0]          length;
    logic                 byte_valid;
    logic [7:0]           byte_data;
    logic                 byte_ready;
    logic                 we;
    logic [HALF_WORD-1:0] instr;
    logic [WORD-1:0]      addr;
    logic                 cpu_reset;
    logic                 busy;
    logic                 done;
    logic                 error;

    int total = 0;
    int bad   = 0;
    int strobes = 0;
    int cyc = 0;
    int s0;
    int c0;

    program_loader dut (
        .clk_i                  (clk),
        .reset_i                (rst),
        .start_i                (start),
        .length_i               (length),
        .byte_valid_i           (byte_valid),
        .byte_data_i            (byte_data),
        .byte_ready_o           (byte_ready),
        .program_mem_write_en_o (we),
        .instruction_o          (instr),
        .instruction_addr_o     (addr),
        .cpu_reset_o            (cpu_reset),
        .busy_o                 (busy),
        .done_o                 (done),
        .error_o                (error)
    );

    always #5 clk = ~clk;

    // Count cycles and write strobes (reads pre-edge values).
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (we) strobes = strobes + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        if (obs !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic do_start(input logic [15:0] len);
        start  = 1'b1;
        length = len;
        tick();
        start  = 1'b0;
    endtask

    // Offer one byte and return on the negedge after it has been accepted.
    task automatic send_byte(input logic [7:0] b);
        bit taken;
        taken = 1'b0;
        byte_valid = 1'b1;
        byte_data  = b;
        for (int i = 0; i < 20 && !taken; i++) begin
            if (byte_ready) taken = 1'b1;
            tick();
        end
        if (!taken) chk("byte_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; length = 16'd0; byte_valid = 1'b0; byte_data = 8'd0;

        // Reset state
        do_reset();
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_ready", 32'(byte_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);

        // Normal two-halfword load, bytes back-to-back
        s0 = strobes;
        do_start(16'd2);
        c0 = cyc;
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_ready", 32'(byte_ready), 32'd1);
        send_byte(8'h34);
        send_byte(8'h12);
        chk("t1_we0", 32'(we), 32'd1);
        chk("t1_instr0", 32'(instr), 32'h1234);
        chk("t1_addr0", 32'(addr), 32'h0);
        chk("t1_cpu_reset_mid", 32'(cpu_reset), 32'd1);
        send_byte(8'h78);
        send_byte(8'h56);
        byte_valid = 1'b0;
        chk("t1_we1", 32'(we), 32'd1);
        chk("t1_instr1", 32'(instr), 32'h5678);
        chk("t1_addr1", 32'(addr), 32'h2);
        tick();
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_cpu_run", 32'(cpu_reset), 32'd0);
        chk("t1_busy_end", 32'(busy), 32'd0);
        chk("t1_cycles", 32'(cyc - c0), 32'd6);
        chk("t1_strobes", 32'(strobes - s0), 32'd2);

        // Invalid / boundary lengths
        do_reset();
        s0 = strobes;
        do_start(16'd1025);
        chk("t2_error", 32'(error), 32'd1);
        chk("t2_busy", 32'(busy), 32'd0);
        chk("t2_cpu_reset", 32'(cpu_reset), 32'd1);
        tick();
        chk("t2_no_strobe", 32'(strobes - s0), 32'd0);
        do_start(16'd0);
        chk("t2_len0_done", 32'(done), 32'd1);
        chk("t2_len0_cpu", 32'(cpu_reset), 32'd0);
        chk("t2_len0_err", 32'(error), 32'd0);
        chk("t2_len0_strobe", 32'(strobes - s0), 32'd0);
        do_reset();
        do_start(16'd1024);
        chk("t2_max_busy", 32'(busy), 32'd1);
        chk("t2_max_err", 32'(error), 32'd0);
        do_start(16'd1025);
        chk("t2_busy_ignore_err", 32'(error), 32'd0);
        chk("t2_busy_still", 32'(busy), 32'd1);

        // Stalled source: valid 1,0,0,1
        do_reset();
        s0 = strobes;
        do_start(16'd1);
        byte_valid = 1'b1; byte_data = 8'hAB;
        tick();
        byte_valid = 1'b0; byte_data = 8'hFF;
        tick();
        chk("t3_stall_ready", 32'(byte_ready), 32'd1);
        chk("t3_stall_nostrobe", 32'(strobes - s0), 32'd0);
        tick();
        chk("t3_stall2_ready", 32'(byte_ready), 32'd1);
        chk("t3_stall2_we", 32'(we), 32'd0);
        byte_valid = 1'b1; byte_data = 8'hCD;
        tick();
        byte_valid = 1'b0;
        chk("t3_we", 32'(we), 32'd1);
        chk("t3_instr", 32'(instr), 32'hCDAB);
        chk("t3_addr", 32'(addr), 32'h0);
        tick();
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_strobes", 32'(strobes - s0), 32'd1);

        // Async reset between low and high byte (reload from RUN first)
        do_start(16'd2);
        chk("t4_reload_cpu", 32'(cpu_reset), 32'd1);
        chk("t4_reload_done", 32'(done), 32'd0);
        send_byte(8'h11);
        byte_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t4_ar_cpu", 32'(cpu_reset), 32'd1);
        chk("t4_ar_ready", 32'(byte_ready), 32'd0);
        chk("t4_ar_busy", 32'(busy), 32'd0);
        chk("t4_ar_done", 32'(done), 32'd0);
        chk("t4_ar_we", 32'(we), 32'd0);
        chk("t4_ar_instr", 32'(instr), 32'd0);
        chk("t4_ar_addr", 32'(addr), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        s0 = strobes;
        do_start(16'd1);
        send_byte(8'h22);
        send_byte(8'h33);
        byte_valid = 1'b0;
        chk("t4_instr", 32'(instr), 32'h3322);
        chk("t4_addr", 32'(addr), 32'h0);
        tick();
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_strobes", 32'(strobes - s0), 32'd1);

        // Reload from RUN, start while busy ignored
        s0 = strobes;
        do_start(16'd1);
        chk("t5_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_busy", 32'(busy), 32'd1);
        start = 1'b1; length = 16'd5;
        send_byte(8'h9A);
        send_byte(8'hBC);
        start = 1'b0; byte_valid = 1'b0;
        chk("t5_we", 32'(we), 32'd1);
        chk("t5_instr", 32'(instr), 32'hBC9A);
        chk("t5_addr", 32'(addr), 32'h0);
        tick();
        chk("t5_run", 32'(done), 32'd1);
        chk("t5_cpu_run", 32'(cpu_reset), 32'd0);
        chk("t5_err", 32'(error), 32'd0);
        tick();
        chk("t5_strobes", 32'(strobes - s0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
